execute_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, fed from the execute pipeline register.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/execute_muldiv_if.sv | 28 ++
 rtl/muldiv_operand_prep.sv | 41 ++++
 rtl/execute_muldiv.sv | 168 ++++++++++++++++
 tb/tb_execute_muldiv.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: funct3 opcodes, FSM states and
// counter width.
package muldiv_pkg;

  localparam int unsigned MULDIV_DATA_WIDTH = 32;
  localparam int unsigned MULDIV_CNT_W      = $clog2(MULDIV_DATA_WIDTH);

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/execute_muldiv_if.sv
// Execute-stage <-> multiply/divide unit signals. The pipeline is the master, the unit the slave.
interface execute_muldiv_if #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned REG_FILE_ADDR_WIDTH = 5
);

  logic                           starte;
  logic [2:0]                     funct3e;
  logic [DATA_WIDTH-1:0]          opae;
  logic [DATA_WIDTH-1:0]          opbe;
  logic [REG_FILE_ADDR_WIDTH-1:0] rde;
  logic                           flush;
  logic                           stall;
  logic                           done;
  logic [DATA_WIDTH-1:0]          result;
  logic [REG_FILE_ADDR_WIDTH-1:0] rdm;

  modport master (
    output starte, funct3e, opae, opbe, rde, flush,
    input  stall, done, result, rdm
  );

  modport slave (
    input  starte, funct3e, opae, opbe, rde, flush,
    output stall, done, result, rdm
  );

endinterface

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation: per-op signedness, operand magnitudes and the flags telling
// the unit whether to negate the product/quotient and the remainder.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  muldiv_op_e            op_i,
  input  logic [DATA_WIDTH-1:0] opa_i,
  input  logic [DATA_WIDTH-1:0] opb_i,
  output logic [DATA_WIDTH-1:0] abs_a_o,
  output logic [DATA_WIDTH-1:0] abs_b_o,
  output logic                  neg_res_o,
  output logic                  neg_rem_o,
  output logic                  is_div_o
);

  logic a_signed, b_signed, a_neg, b_neg;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (op_i)
      OpMul, OpMulh, OpDiv, OpRem: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OpMulhsu: a_signed = 1'b1;
      default:  ;
    endcase
    a_neg     = a_signed & opa_i[DATA_WIDTH-1];
    b_neg     = b_signed & opb_i[DATA_WIDTH-1];
    abs_a_o   = a_neg ? -opa_i : opa_i;
    abs_b_o   = b_neg ? -opb_i : opb_i;
    neg_res_o = a_neg ^ b_neg;
    // Remainder follows the dividend's sign.
    neg_rem_o = a_neg;
    is_div_o  = op_i[2];
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage; stalls the front end while
// it computes. Optional MULDIV_FAST_MUL_EN makes MUL* ops single-cycle via the '*' operator.
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned REG_FILE_ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             rstn,
  execute_muldiv_if.slave bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = (DATA_WIDTH == MULDIV_DATA_WIDTH) ? MULDIV_CNT_W
                                                                   : $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  muldiv_state_e                  state_q;
  logic [CntW-1:0]                cnt_q;
  muldiv_op_e                     op_q;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_q, rdm_q;
  logic [W-1:0]                   opb_q, result_q;
  logic [2*W-1:0]                 acc_q;
  logic                           neg_res_q, neg_rem_q, done_q;

  muldiv_op_e     op_in;
  logic [W-1:0]   abs_a, abs_b, fast_res;
  logic           neg_res, neg_rem, is_div, accept, ovf, fast_path;
  logic [2*W-1:0] step_acc;
  logic [W:0]     mul_sum, rem_sh, diff;

  assign op_in = muldiv_op_e'(bus.funct3e);

  muldiv_operand_prep #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_prep (
    .op_i     (op_in),
    .opa_i    (bus.opae),
    .opb_i    (bus.opbe),
    .abs_a_o  (abs_a),
    .abs_b_o  (abs_b),
    .neg_res_o(neg_res),
    .neg_rem_o(neg_rem),
    .is_div_o (is_div)
  );

  // Acc layout: multiply {product}, divide {remainder, quotient}.
  function automatic logic [W-1:0] final_result(input muldiv_op_e op, input logic [2*W-1:0] acc,
                                                input logic neg_r, input logic neg_m);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;
    prod = neg_r ? -acc : acc;
    quo  = neg_r ? -acc[W-1:0] : acc[W-1:0];
    rem  = neg_m ? -acc[2*W-1:W] : acc[2*W-1:W];
    unique case (op)
      OpMul:                     final_result = prod[W-1:0];
      OpMulh, OpMulhsu:          final_result = prod[2*W-1:W];
      OpDiv:                     final_result = quo;
      OpRem:                     final_result = rem;
      OpMulhu:                   final_result = acc[2*W-1:W];
      OpDivu:                    final_result = acc[W-1:0];
      default:                   final_result = acc[2*W-1:W];
    endcase
  endfunction

  assign accept = (state_q == StIdle) & bus.starte & ~bus.flush;
  assign ovf    = is_div & ~op_in[0] & (bus.opae == {1'b1, {(W-1){1'b0}}}) & (bus.opbe == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
`endif

  always_comb begin
    fast_path = 1'b0;
    fast_res  = '0;
    if (is_div && bus.opbe == '0) begin
      fast_path = 1'b1;
      fast_res  = op_in[1] ? bus.opae : '1;
    end else if (ovf) begin
      fast_path = 1'b1;
      fast_res  = op_in[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) begin
      fast_path = 1'b1;
      fast_res  = final_result(op_in, fast_prod, neg_res, neg_rem);
    end
`endif
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = acc_q[2*W-1:W-1];
    diff     = rem_sh - {1'b0, opb_q};
    step_acc = acc_q;
    if (!op_q[2]) begin
      step_acc = {mul_sum, acc_q[W-1:1]};
    end else if (!diff[W]) begin
      step_acc = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      step_acc = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OpMul;
      rd_q      <= '0;
      rdm_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q      <= op_in;
            rd_q      <= bus.rde;
            opb_q     <= abs_b;
            acc_q     <= {{W{1'b0}}, abs_a};
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
            cnt_q     <= '0;
            if (fast_path) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= fast_res;
              rdm_q    <= bus.rde;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            acc_q <= step_acc;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= final_result(op_q, step_acc, neg_res_q, neg_rem_q);
              rdm_q    <= rd_q;
            end
          end
        end
        // The completed instruction is still in execute here, so starte is ignored.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stall  = rstn & (accept | (state_q == StCalc));
  assign bus.done   = rstn & done_q & ~bus.flush;
  assign bus.result = result_q;
  assign bus.rdm    = rdm_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed self-checking bench for execute_muldiv: multiply, divide, fast paths, flush, reset.
module tb_execute_muldiv;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulStalls = 1;
`else
  localparam int MulStalls = 33;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  execute_muldiv_if #(.DATA_WIDTH(32), .REG_FILE_ADDR_WIDTH(5)) bus ();

  execute_muldiv #(
    .DATA_WIDTH         (32),
    .REG_FILE_ADDR_WIDTH(5)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Presents one op and holds it until done; returns the observed outcome.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output int stalls, output logic stall_at_done, output bit ok);
    @(negedge clk);
    bus.starte  = 1'b1;
    bus.flush   = 1'b0;
    bus.funct3e = f;
    bus.opae    = a;
    bus.opbe    = b;
    bus.rde     = rd;
    stalls = 0;
    ok     = 1'b0;
    res    = 'x;
    rdo    = 'x;
    stall_at_done = 1'bx;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.done === 1'b1) begin
        res = bus.result;
        rdo = bus.rdm;
        stall_at_done = bus.stall;
        ok  = 1'b1;
        break;
      end
      if (bus.stall === 1'b1) stalls++;
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.starte = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.starte  = 1'b1;
    bus.funct3e = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_tests++; if (bus.rdm !== 5'h0) begin n_fail++; $display("FAIL reset_rdm: got %h want 0", bus.rdm); end
    bus.starte = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  f   [5] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b001};
    logic [31:0] a   [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b   [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000};
    logic [31:0] exp [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h4000_0000};
    logic [31:0] r;
    logic [4:0]  rd;
    logic        sd;
    int          st;
    bit          ok;
    for (int i = 0; i < 5; i++) begin
      do_op(f[i], a[i], b[i], 5'(i + 5), r, rd, st, sd, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL mul%0d_done: no done pulse within bound", i); end
      n_tests++; if (r !== exp[i]) begin n_fail++; $display("FAIL mul%0d_result: got %h want %h", i, r, exp[i]); end
      n_tests++; if (rd !== 5'(i + 5)) begin n_fail++; $display("FAIL mul%0d_rdm: got %0d want %0d", i, rd, i + 5); end
      n_tests++; if (st != MulStalls) begin n_fail++; $display("FAIL mul%0d_stalls: got %0d want %0d", i, st, MulStalls); end
      n_tests++; if (sd !== 1'b0) begin n_fail++; $display("FAIL mul%0d_stall_in_done: got %b want 0", i, sd); end
      idle();
      #1;
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul%0d_done_pulse: got %b want 0", i, bus.done); end
      n_tests++; if (bus.result !== exp[i]) begin n_fail++; $display("FAIL mul%0d_hold: got %h want %h", i, bus.result, exp[i]); end
    end
  endtask

  task automatic run_div_table(input string tag, input logic [2:0] f [6], input logic [31:0] a [6],
                               input logic [31:0] b [6], input logic [31:0] exp [6],
                               input int want_st);
    logic [31:0] r;
    logic [4:0]  rd;
    logic        sd;
    int          st;
    bit          ok;
    for (int i = 0; i < 6; i++) begin
      do_op(f[i], a[i], b[i], 5'(i + 10), r, rd, st, sd, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL %s%0d_done: no done pulse within bound", tag, i); end
      n_tests++; if (r !== exp[i]) begin n_fail++; $display("FAIL %s%0d_result: got %h want %h", tag, i, r, exp[i]); end
      n_tests++; if (rd !== 5'(i + 10)) begin n_fail++; $display("FAIL %s%0d_rdm: got %0d want %0d", tag, i, rd, i + 10); end
      n_tests++; if (st != want_st) begin n_fail++; $display("FAIL %s%0d_stalls: got %0d want %0d", tag, i, st, want_st); end
      idle();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f   [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] a   [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] b   [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    run_div_table("div", f, a, b, exp, 33);
  endtask

  task automatic test_div_special();
    logic [2:0]  f   [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a   [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB,
                             32'hFFFF_FFFB};
    logic [31:0] b   [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFB};
    run_div_table("spec", f, a, b, exp, 1);
  endtask

  task automatic test_flush();
    logic [31:0] r;
    logic [4:0]  rd;
    logic        sd;
    int          st;
    int          dones;
    bit          ok;
    @(negedge clk);
    bus.starte  = 1'b1;
    bus.funct3e = 3'b101;
    bus.opae    = 32'd1000;
    bus.opbe    = 32'd3;
    bus.rde     = 5'd3;
    repeat (11) @(negedge clk);
    bus.flush  = 1'b1;
    bus.starte = 1'b0;
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_same: got %b want 1", bus.stall); end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_next: got %b want 0", bus.stall); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", dones); end
    // flush beats starte in IDLE
    @(negedge clk);
    bus.starte = 1'b1;
    bus.flush  = 1'b1;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 0", bus.stall); end
    @(negedge clk);
    bus.starte = 1'b0;
    bus.flush  = 1'b0;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accept: got %b want 0", bus.stall); end
    do_op(3'b101, 32'd9, 32'd3, 5'd4, r, rd, st, sd, ok);
    n_tests++; if (!ok || r !== 32'd3) begin n_fail++; $display("FAIL flush_next_op: got %h (done %0b) want 3", r, ok); end
    n_tests++; if (st != 33) begin n_fail++; $display("FAIL flush_next_stalls: got %0d want 33", st); end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.starte  = 1'b1;
    bus.funct3e = 3'b000;
    bus.opae    = 32'd11;
    bus.opbe    = 32'd13;
    bus.rde     = 5'd9;
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall_comb: got %b want 0", bus.stall); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", bus.stall); end
    bus.starte = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b want 0", bus.stall); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    logic [4:0]  rd1, rd2;
    logic        sd;
    int          st;
    bit          ok1, ok2;
    do_op(3'b000, 32'd2, 32'd3, 5'd1, r1, rd1, st, sd, ok1);
    do_op(3'b000, 32'd4, 32'd5, 5'd2, r2, rd2, st, sd, ok2);
    n_tests++; if (!ok1 || r1 !== 32'd6 || rd1 !== 5'd1) begin n_fail++; $display("FAIL b2b_first: got %h rd %0d want 6 rd 1", r1, rd1); end
    n_tests++; if (!ok2 || r2 !== 32'd20 || rd2 !== 5'd2) begin n_fail++; $display("FAIL b2b_second: got %h rd %0d want 20 rd 2", r2, rd2); end
    n_tests++; if (st != MulStalls) begin n_fail++; $display("FAIL b2b_stalls: got %0d want %0d", st, MulStalls); end
    idle();
  endtask

  initial begin
    bus.starte  = 1'b0;
    bus.flush   = 1'b0;
    bus.funct3e = 3'b000;
    bus.opae    = '0;
    bus.opbe    = '0;
    bus.rde     = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
